// File: rtl/ascii_cmd_parser_if.sv
// Byte-stream in / command-result out bundle between the UART RX side and
// the ASCII command parser.
interface ascii_cmd_parser_if #(
  parameter int VALUE_W = 14
);
  logic [7:0]         i_Data;
  logic               i_Valid;
  logic [VALUE_W-1:0] o_Value;
  logic               o_Dir;
  logic               o_Done;
  logic               o_Error;
  logic               o_Busy;

  modport master (
    output i_Data, i_Valid,
    input  o_Value, o_Dir, o_Done, o_Error, o_Busy
  );

  modport slave (
    input  i_Data, i_Valid,
    output o_Value, o_Dir, o_Done, o_Error, o_Busy
  );
endinterface

// File: rtl/ascii_cmd_parser.sv
// Assembles "[+|-][spaces]digits[spaces]ENTER" from a UART byte stream into a
// magnitude plus direction, pulsing done on a good command and error otherwise.
//
// state  | meaning
// IDLE   | waiting for first non-space byte of a command
// SIGN   | sign seen, waiting for first digit
// DIGITS | accumulating decimal digits
// TRAIL  | trailing spaces after the number, waiting for ENTER
// ERR    | malformed command, discarding bytes until ENTER
module ascii_cmd_parser #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int MAX_VALUE  = 9999
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  ascii_cmd_parser_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SIGN   = 3'd1;
  localparam logic [2:0] DIGITS = 3'd2;
  localparam logic [2:0] TRAIL  = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam int                 CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [VALUE_W-1:0] VAL_MAX = VALUE_W'(MAX_VALUE);

  logic [2:0]         state, state_nxt;
  logic [VALUE_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               dir_r, dir_nxt;
  logic               commit, fail;
  logic               is_digit, is_plus, is_minus, is_space, is_enter;
  logic [VALUE_W+3:0] prod;
  logic               in_range;

  assign is_digit = (bus.i_Data >= 8'h30) && (bus.i_Data <= 8'h39);
  assign is_plus  = (bus.i_Data == 8'h2B);
  assign is_minus = (bus.i_Data == 8'h2D);
  assign is_space = (bus.i_Data == 8'h20);
  assign is_enter = (bus.i_Data == 8'h0D);

  // Widened so the multiply-accumulate cannot wrap before truncation.
  assign prod = (VALUE_W+4)'(acc) * (VALUE_W+4)'(10) + (VALUE_W+4)'(bus.i_Data[3:0]);
  assign in_range = (acc <= VAL_MAX);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    dir_nxt   = dir_r;
    commit    = 1'b0;
    fail      = 1'b0;
    if (bus.i_Valid) begin
      case (state)
        IDLE: begin
          if (is_plus || is_minus) begin
            dir_nxt   = is_minus;
            state_nxt = SIGN;
          end else if (is_digit) begin
            acc_nxt   = VALUE_W'(bus.i_Data[3:0]);
            cnt_nxt   = CNT_W'(1);
            dir_nxt   = 1'b0;
            state_nxt = DIGITS;
          end else if (!is_space && !is_enter) begin
            state_nxt = ERR;
          end
        end
        SIGN: begin
          if (is_digit) begin
            acc_nxt   = VALUE_W'(bus.i_Data[3:0]);
            cnt_nxt   = CNT_W'(1);
            state_nxt = DIGITS;
          end else if (is_enter) begin
            fail      = 1'b1;
            state_nxt = IDLE;
          end else if (!is_space) begin
            state_nxt = ERR;
          end
        end
        DIGITS: begin
          if (is_digit) begin
            if (cnt < CNT_MAX) begin
              acc_nxt = prod[VALUE_W-1:0];
              cnt_nxt = cnt + CNT_W'(1);
            end else begin
              state_nxt = ERR;
            end
          end else if (is_space) begin
            state_nxt = TRAIL;
          end else if (is_enter) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = ERR;
          end
        end
        TRAIL: begin
          if (is_enter) begin
            commit    = 1'b1;
            state_nxt = IDLE;
          end else if (!is_space) begin
            state_nxt = ERR;
          end
        end
        ERR: begin
          if (is_enter) begin
            fail      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      dir_r       <= 1'b0;
      bus.o_Value <= '0;
      bus.o_Dir   <= 1'b0;
      bus.o_Done  <= 1'b0;
      bus.o_Error <= 1'b0;
      bus.o_Busy  <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      cnt         <= cnt_nxt;
      dir_r       <= dir_nxt;
      bus.o_Done  <= commit && in_range;
      bus.o_Error <= fail || (commit && !in_range);
      bus.o_Busy  <= (state_nxt != IDLE);
      if (commit && in_range) begin
        bus.o_Value <= acc;
        bus.o_Dir   <= dir_r;
      end
    end
  end
endmodule
